// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS-lite CPU,
// including EPC capture and a RUN/HANDLER machine for single-level interrupts.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_off,
    input  logic        jump,
    input  logic [25:0] jump_tgt,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        irq,
    input  logic        int_en,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        exc_taken
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        exc_q, exc_d;

    logic [31:0] pc_inc;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] seq_next;
    logic        take_irq;
    logic        take_eret;

    assign pc_inc        = pc_q + 32'd4;
    assign branch_target = pc_inc + {{14{branch_off[15]}}, branch_off, 2'b00};
    assign jump_target   = {pc_inc[31:28], jump_tgt, 2'b00};
    // jr silently drops the byte-offset bits instead of faulting on misalignment
    assign jr_target     = jr_addr & 32'hFFFF_FFFC;

    always_comb begin
        seq_next = pc_inc;
        if (jr) begin
            seq_next = jr_target;
        end else if (jump) begin
            seq_next = jump_target;
        end else if (branch_taken) begin
            seq_next = branch_target;
        end
    end

    assign take_irq  = (state_q == RUN) && irq && int_en;
    assign take_eret = (state_q == HANDLER) && eret;

    // The redirect computed this cycle is what gets saved on interrupt entry
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        exc_d   = 1'b0;
        if (!stall) begin
            if (take_irq) begin
                epc_d   = seq_next;
                pc_d    = EXC_VECTOR;
                state_d = HANDLER;
                exc_d   = 1'b1;
            end else if (take_eret) begin
                pc_d    = epc_q;
                state_d = RUN;
            end else begin
                pc_d    = seq_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            exc_q   <= exc_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_inc;
    assign epc        = epc_q;
    assign in_handler = (state_q == HANDLER);
    assign exc_taken  = exc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a driver pushes model predictions per
// cycle into a queue and an independent monitor pops and compares after each edge.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic        jump;
    logic [25:0] jump_tgt;
    logic        jr;
    logic [31:0] jr_addr;
    logic        irq;
    logic        int_en;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        in_handler;
    logic        exc_taken;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        inh;
        logic        exc;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycleId     = 0;

    logic [31:0] mPc;
    logic [31:0] mEpc;
    logic        mHandler;
    logic        mExc;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump         (jump),
        .jump_tgt     (jump_tgt),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .irq          (irq),
        .int_en       (int_en),
        .eret         (eret),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc),
        .in_handler   (in_handler),
        .exc_taken    (exc_taken)
    );

    task automatic checkOutput(input string name, input exp_t e);
        testsRun++;
        if (pc !== e.pc) begin
            testsFailed++;
            $display("[TB] FAIL %s pc: got %h expected %h", name, pc, e.pc);
        end
        testsRun++;
        if (pc_plus4 !== e.pc + 32'd4) begin
            testsFailed++;
            $display("[TB] FAIL %s pc_plus4: got %h expected %h", name, pc_plus4, e.pc + 32'd4);
        end
        testsRun++;
        if (epc !== e.epc) begin
            testsFailed++;
            $display("[TB] FAIL %s epc: got %h expected %h", name, epc, e.epc);
        end
        testsRun++;
        if (in_handler !== e.inh) begin
            testsFailed++;
            $display("[TB] FAIL %s in_handler: got %b expected %b", name, in_handler, e.inh);
        end
        testsRun++;
        if (exc_taken !== e.exc) begin
            testsFailed++;
            $display("[TB] FAIL %s exc_taken: got %b expected %b", name, exc_taken, e.exc);
        end
    endtask

    // Monitor: every edge that has a prediction queued gets compared
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("cycle%0d", e.id), e);
        end
    end

    task automatic modelReset();
        mPc      = 32'h0000_0000;
        mEpc     = 32'h0000_0000;
        mHandler = 1'b0;
        mExc     = 1'b0;
    endtask

    // Drive one cycle of inputs (no waiting) and queue the predicted post-edge state
    task automatic setAndPush(input logic st, input logic br, input logic [15:0] off,
                              input logic jmp, input logic [25:0] tgt, input logic jrv,
                              input logic [31:0] jra, input logic irqv, input logic ie,
                              input logic er);
        logic [31:0] nextSeq;
        logic [31:0] plus4;
        exp_t        e;
        stall = st; branch_taken = br; branch_off = off; jump = jmp; jump_tgt = tgt;
        jr = jrv; jr_addr = jra; irq = irqv; int_en = ie; eret = er;
        plus4 = mPc + 32'd4;
        if (jrv)      nextSeq = (jra / 4) * 4;
        else if (jmp) nextSeq = {plus4[31:28], 28'd0} + {4'd0, tgt, 2'b00};
        else if (br)  nextSeq = plus4 + ({{16{off[15]}}, off} * 32'd4);
        else          nextSeq = plus4;
        mExc = 1'b0;
        if (st) begin
            // frozen cycle
        end else if (!mHandler && irqv && ie) begin
            mEpc = nextSeq; mPc = 32'h0000_0040; mHandler = 1'b1; mExc = 1'b1;
        end else if (mHandler && er) begin
            mPc = mEpc; mHandler = 1'b0;
        end else begin
            mPc = nextSeq;
        end
        e.id = cycleId; e.pc = mPc; e.epc = mEpc; e.inh = mHandler; e.exc = mExc;
        cycleId++;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [15:0] off,
                                 input logic jmp, input logic [25:0] tgt, input logic jrv,
                                 input logic [31:0] jra, input logic irqv, input logic ie,
                                 input logic er);
        @(negedge clk);
        setAndPush(st, br, off, jmp, tgt, jrv, jra, irqv, ie, er);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jrTo(input logic [31:0] a);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, a, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted mid-cycle, checked while low, released before the next edge
    task automatic pulseReset(input string name);
        exp_t e;
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        irq = 1'b0; int_en = 1'b0; eret = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        e.id = -1; e.pc = 32'h0; e.epc = 32'h0; e.inh = 1'b0; e.exc = 1'b0;
        checkOutput(name, e);
        #1 rst_n = 1'b1;
        setAndPush(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        exp_t e;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_off = 16'h0;
        jump = 1'b0; jump_tgt = 26'h0; jr = 1'b0; jr_addr = 32'h0;
        irq = 1'b0; int_en = 1'b0; eret = 1'b0;
        modelReset();
        @(negedge clk);
        e.id = -1; e.pc = 32'h0; e.epc = 32'h0; e.inh = 1'b0; e.exc = 1'b0;
        checkOutput("reset", e);
        rst_n = 1'b1;
        setAndPush(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (4) idleCycle();
        applyStimulus(1'b0, 1'b1, 16'h0001, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idleCycle();
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        jrTo(32'h10);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        jrTo(32'h33);
        applyStimulus(1'b0, 1'b1, 16'h0005, 1'b1, 26'h3, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        jrTo(32'h10);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        jrTo(32'h08);
        applyStimulus(1'b0, 1'b1, 16'h0001, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        pulseReset("reset_in_handler");
        jrTo(32'hFFFF_FFFC);
        idleCycle();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(59) == 0) begin
                pulseReset($sformatf("rand_reset%0d", i));
            end else begin
                applyStimulus(logic'($urandom_range(7) == 0), logic'($urandom_range(3) == 0),
                              16'($urandom), logic'($urandom_range(9) == 0), 26'($urandom),
                              logic'($urandom_range(9) == 0), $urandom,
                              logic'($urandom_range(3) == 0), logic'($urandom_range(1)),
                              logic'($urandom_range(5) == 0));
            end
        end
        @(posedge clk);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
